// File: rtl/dc_motor_pwm_ctrl.sv
// rtl/dc_motor_pwm_ctrl.sv - single-motor H-bridge PWM controller with ramping, dead time and brake
//
// Purpose: prescaled PWM carrier (period PERIOD ticks, tick = PRESCALE clks) whose duty is
// applied only at period boundaries. Direction reversal and run release ramp the duty to zero,
// then hold both bridge inputs low for DEAD_PERIODS full periods. Brake overrides everything.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   en                run request (low = ramp down, then coast)
//   dir               requested direction (0 = forward on in_a, 1 = reverse on in_b)
//   brake             immediate brake (in_a = in_b = 1)
//   duty_set[CNT_W]   target duty in counter ticks, clamped to PERIOD
//   in_a, in_b        registered H-bridge inputs
//   duty_cur[CNT_W]   duty currently applied
//   busy              state is not IDLE
//
// Optional feature macro: SOFT_START_EN
//   defined   - duty moves by at most RAMP_STEP per period boundary
//   undefined - duty jumps straight to its goal at each boundary
module dc_motor_pwm_ctrl #(
  parameter int CNT_W        = 12,
  parameter int PRESCALE     = 256,
  parameter int PERIOD       = 2000,
  parameter int RAMP_STEP    = 16,
  parameter int DEAD_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             brake,
  input  logic [CNT_W-1:0] duty_set,
  output logic             in_a,
  output logic             in_b,
  output logic [CNT_W-1:0] duty_cur,
  output logic             busy
);

  localparam int PSC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DEAD_W = $clog2(DEAD_PERIODS + 1) + 1;
`ifdef SOFT_START_EN
  localparam int STEP_MAX = RAMP_STEP;
`else
  // A step at least one full period wide always lands on the goal in one boundary.
  localparam int STEP_MAX = (RAMP_STEP > PERIOD) ? RAMP_STEP : PERIOD;
`endif

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_RAMP_DN = 3'd2;
  localparam logic [2:0] S_DEAD    = 3'd3;
  localparam logic [2:0] S_BRAKE   = 3'd4;

  logic [PSC_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]  duty_q, duty_d;
  logic [2:0]        state_q, state_d;
  logic              dir_cur_q, dir_cur_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic              in_a_q, in_a_d;
  logic              in_b_q, in_b_d;

  logic              tick;
  logic              boundary;
  logic              pwm;
  logic              run_req;
  logic [CNT_W-1:0]  target;
  logic [CNT_W-1:0]  stepped;

  // Move cur toward goal by at most STEP_MAX without overshooting.
  function automatic logic [CNT_W-1:0] ramp_to(input logic [CNT_W-1:0] cur,
                                               input logic [CNT_W-1:0] goal);
    logic [CNT_W-1:0] diff;
    if (goal >= cur) begin
      diff    = goal - cur;
      ramp_to = (32'(diff) > STEP_MAX) ? cur + CNT_W'(STEP_MAX) : goal;
    end else begin
      diff    = cur - goal;
      ramp_to = (32'(diff) > STEP_MAX) ? cur - CNT_W'(STEP_MAX) : goal;
    end
  endfunction

  always_comb begin
    tick     = (presc_q == PSC_W'(PRESCALE - 1));
    boundary = tick && (pc_q == CNT_W'(PERIOD - 1));
    presc_d  = tick ? '0 : presc_q + 1'b1;
    pc_d     = pc_q;
    if (tick) begin
      pc_d = boundary ? '0 : pc_q + 1'b1;
    end

    target  = (duty_set > CNT_W'(PERIOD)) ? CNT_W'(PERIOD) : duty_set;
    // Keep running only while the request matches the direction being driven.
    run_req = en && (dir == dir_cur_q);
    stepped = ramp_to(duty_q, run_req ? target : '0);

    state_d   = state_q;
    duty_d    = duty_q;
    dir_cur_d = dir_cur_q;
    dead_d    = dead_q;

    if (brake) begin
      state_d = S_BRAKE;
      duty_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) begin
            state_d   = S_RUN;
            dir_cur_d = dir;
          end
        end
        S_RUN, S_RAMP_DN: begin
          state_d = run_req ? S_RUN : S_RAMP_DN;
          if (boundary) begin
            duty_d = stepped;
            if (!run_req && (stepped == '0)) begin
              state_d = S_DEAD;
              // Entered on a boundary: the period now starting is the first full dead period.
              dead_d  = DEAD_W'(1);
            end
          end
        end
        S_DEAD: begin
          if (boundary) begin
            if (dead_q == DEAD_W'(DEAD_PERIODS)) begin
              if (en) begin
                state_d   = S_RUN;
                dir_cur_d = dir;
                duty_d    = ramp_to('0, target);
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              dead_d = dead_q + 1'b1;
            end
          end
        end
        S_BRAKE: begin
          state_d = S_DEAD;
          // Released mid-period: the partial period does not count toward dead time.
          dead_d  = boundary ? DEAD_W'(1) : '0;
        end
        default: begin
          state_d = S_IDLE;
          duty_d  = '0;
        end
      endcase
    end

    // Drive mode follows the next state so brake lands on the very next clk;
    // the pwm level comes from the registered counter and duty.
    pwm    = (pc_q < duty_q);
    in_a_d = 1'b0;
    in_b_d = 1'b0;
    case (state_d)
      S_RUN, S_RAMP_DN: begin
        if (dir_cur_d) begin
          in_b_d = pwm;
        end else begin
          in_a_d = pwm;
        end
      end
      S_BRAKE: begin
        in_a_d = 1'b1;
        in_b_d = 1'b1;
      end
      default: begin
        in_a_d = 1'b0;
        in_b_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      pc_q      <= '0;
      duty_q    <= '0;
      state_q   <= S_IDLE;
      dir_cur_q <= 1'b0;
      dead_q    <= '0;
      in_a_q    <= 1'b0;
      in_b_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pc_q      <= pc_d;
      duty_q    <= duty_d;
      state_q   <= state_d;
      dir_cur_q <= dir_cur_d;
      dead_q    <= dead_d;
      in_a_q    <= in_a_d;
      in_b_q    <= in_b_d;
    end
  end

  assign in_a     = in_a_q;
  assign in_b     = in_b_q;
  assign duty_cur = duty_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dc_motor_pwm_ctrl.sv
// tb/tb_dc_motor_pwm_ctrl.sv - self-checking bench for dc_motor_pwm_ctrl
module tb_dc_motor_pwm_ctrl;

  localparam int CW      = 12;
  localparam int PS      = 4;
  localparam int PER     = 100;
  localparam int RS      = 25;
  localparam int DP      = 2;
  localparam int CYC_PER = PS * PER;
`ifdef SOFT_START_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DOWN = 2;
  localparam int M_DEAD = 3;
  localparam int M_BRK  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          dir = 1'b0;
  logic          brake = 1'b0;
  logic [CW-1:0] duty_set = '0;
  logic          in_a, in_b, busy;
  logic [CW-1:0] duty_cur;

  int total = 0;
  int bad   = 0;

  // reference model: cycle count since reset plus mode/duty/direction
  int cyc;
  int m_mode;
  int m_duty;
  bit m_dir;
  int m_dead_end;
  bit m_a, m_b, m_bnd;

  dc_motor_pwm_ctrl #(
    .CNT_W(CW), .PRESCALE(PS), .PERIOD(PER), .RAMP_STEP(RS), .DEAD_PERIODS(DP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .brake(brake), .duty_set(duty_set),
    .in_a(in_a), .in_b(in_b), .duty_cur(duty_cur), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int ramp(int cur, int goal);
    int lim;
    lim = SOFT ? RS : (1 << 30);
    if (goal > cur) return (goal - cur > lim) ? cur + lim : goal;
    return (cur - goal > lim) ? cur - lim : goal;
  endfunction

  function automatic logic [CW+2:0] exp_vec();
    return {m_a, m_b, m_mode != M_IDLE, m_duty[CW-1:0]};
  endfunction

  task automatic model_reset();
    cyc = 0; m_mode = M_IDLE; m_duty = 0; m_dir = 1'b0;
    m_dead_end = 0; m_a = 1'b0; m_b = 1'b0; m_bnd = 1'b0;
  endtask

  // One clock edge of the reference: PWM position is derived from the cycle count,
  // dead time is an absolute end cycle.
  task automatic model_edge();
    int pc, tgt, nm, nd;
    bit pwm, req, ndir;
    pc    = (cyc / PS) % PER;
    m_bnd = ((cyc + 1) % CYC_PER) == 0;
    tgt   = (int'(duty_set) > PER) ? PER : int'(duty_set);
    pwm   = pc < m_duty;
    req   = en && (dir == m_dir);
    nm = m_mode; nd = m_duty; ndir = m_dir;
    if (brake) begin
      nm = M_BRK; nd = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (en) begin nm = M_RUN; ndir = dir; end
        M_RUN, M_DOWN: begin
          nm = req ? M_RUN : M_DOWN;
          if (m_bnd) begin
            nd = ramp(m_duty, req ? tgt : 0);
            if (!req && nd == 0) begin
              nm = M_DEAD;
              m_dead_end = cyc + DP * CYC_PER;
            end
          end
        end
        M_DEAD: if (cyc == m_dead_end) begin
          if (en) begin nm = M_RUN; ndir = dir; nd = ramp(0, tgt); end
          else nm = M_IDLE;
        end
        default: begin
          nm = M_DEAD;
          m_dead_end = (m_bnd ? cyc : ((cyc + 1) / CYC_PER + 1) * CYC_PER - 1) + DP * CYC_PER;
        end
      endcase
    end
    m_a = (nm == M_BRK) || ((nm == M_RUN || nm == M_DOWN) && !ndir && pwm);
    m_b = (nm == M_BRK) || ((nm == M_RUN || nm == M_DOWN) && ndir && pwm);
    m_mode = nm; m_duty = nd; m_dir = ndir;
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total += 4;
    if (in_a !== 1'b0) begin bad++; $display("FAIL reset_in_a got=%b want=0", in_a); end
    if (in_b !== 1'b0) begin bad++; $display("FAIL reset_in_b got=%b want=0", in_b); end
    if (duty_cur !== '0) begin bad++; $display("FAIL reset_duty got=%0d want=0", duty_cur); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_soft_start();
    int exp_s[4] = '{25, 50, 60, 60};
    int high_a, high_b;
    high_b = 0;
    en = 1'b1; dir = 1'b0; duty_set = 60;
    for (int p = 0; p < 4; p++) begin
      high_a = 0;
      for (int i = 0; i < CYC_PER; i++) begin
        step();
        high_a += int'(in_a); high_b += int'(in_b);
        total++;
        if ({in_a, in_b, busy, duty_cur} !== exp_vec()) begin
          bad++; $display("FAIL start_cyc t=%0t got=%h want=%h", $time, {in_a, in_b, busy, duty_cur}, exp_vec());
        end
      end
      total++;
      if (int'(duty_cur) != (SOFT ? exp_s[p] : 60)) begin
        bad++; $display("FAIL start_duty p=%0d got=%0d want=%0d", p, duty_cur, SOFT ? exp_s[p] : 60);
      end
    end
    total += 3;
    if (high_a != 240) begin bad++; $display("FAIL start_high got=%0d want=240", high_a); end
    if (high_b != 0) begin bad++; $display("FAIL start_in_b got=%0d want=0", high_b); end
    if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b want=1", busy); end
  endtask

  task automatic test_clamp();
    int exp_s[3] = '{85, 100, 100};
    int high_a;
    duty_set = 150;
    for (int p = 0; p < 3; p++) begin
      high_a = 0;
      for (int i = 0; i < CYC_PER; i++) begin
        step();
        high_a += int'(in_a);
        total++;
        if ({in_a, in_b, busy, duty_cur} !== exp_vec()) begin
          bad++; $display("FAIL clamp_cyc t=%0t got=%h want=%h", $time, {in_a, in_b, busy, duty_cur}, exp_vec());
        end
      end
      total++;
      if (int'(duty_cur) != (SOFT ? exp_s[p] : 100)) begin
        bad++; $display("FAIL clamp_duty p=%0d got=%0d want=%0d", p, duty_cur, SOFT ? exp_s[p] : 100);
      end
    end
    total++;
    if (high_a != CYC_PER) begin bad++; $display("FAIL clamp_full got=%0d want=%0d", high_a, CYC_PER); end
  endtask

  task automatic test_reverse();
    int rs[8] = '{75, 50, 25, 0, 0, 25, 50, 75};
    int rn[8] = '{0, 0, 100, 100, 100, 100, 100, 100};
    int zb, s, low, overlap;
    zb = SOFT ? 1599 : 399;
    s = 0; low = 0; overlap = 0;
    dir = 1'b1;
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < CYC_PER; i++) begin
        step();
        if (in_a && in_b) overlap++;
        if (s > zb && s <= zb + 800 && !in_a && !in_b) low++;
        if (s == zb + 801) begin
          total++;
          if (in_b !== 1'b1) begin bad++; $display("FAIL rev_restart got=%b want=1", in_b); end
        end
        total++;
        if ({in_a, in_b, busy, duty_cur} !== exp_vec()) begin
          bad++; $display("FAIL rev_cyc t=%0t got=%h want=%h", $time, {in_a, in_b, busy, duty_cur}, exp_vec());
        end
        s++;
      end
      total++;
      if (int'(duty_cur) != (SOFT ? rs[p] : rn[p])) begin
        bad++; $display("FAIL rev_duty p=%0d got=%0d want=%0d", p, duty_cur, SOFT ? rs[p] : rn[p]);
      end
    end
    total += 2;
    if (low != 800) begin bad++; $display("FAIL rev_dead got=%0d want=800", low); end
    if (overlap != 0) begin bad++; $display("FAIL rev_overlap got=%0d want=0", overlap); end
  endtask

  task automatic test_brake();
    int low, high_b;
    low = 0; high_b = 0;
    duty_set = 60;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < CYC_PER; i++) begin
        if (p == 1 && i == 120) brake = 1'b1;
        if (p == 1 && i == 170) brake = 1'b0;
        step();
        if (p == 1 && i == 120) begin
          total += 3;
          if (in_a !== 1'b1) begin bad++; $display("FAIL brake_in_a got=%b want=1", in_a); end
          if (in_b !== 1'b1) begin bad++; $display("FAIL brake_in_b got=%b want=1", in_b); end
          if (duty_cur !== '0) begin bad++; $display("FAIL brake_duty got=%0d want=0", duty_cur); end
        end
        if ((p == 1 && i >= 170) || p == 2 || p == 3) low += int'(!in_a && !in_b);
        if (p == 4) high_b += int'(in_b);
        total++;
        if ({in_a, in_b, busy, duty_cur} !== exp_vec()) begin
          bad++; $display("FAIL brake_cyc t=%0t got=%h want=%h", $time, {in_a, in_b, busy, duty_cur}, exp_vec());
        end
      end
      if (p == 0 || p == 3) begin
        total++;
        if (int'(duty_cur) != ((p == 0 || !SOFT) ? 60 : 25)) begin
          bad++; $display("FAIL brake_pduty p=%0d got=%0d want=%0d", p, duty_cur, (p == 0 || !SOFT) ? 60 : 25);
        end
      end
    end
    total += 2;
    if (low != 1030) begin bad++; $display("FAIL brake_coast got=%0d want=1030", low); end
    if (high_b != (SOFT ? 100 : 240)) begin bad++; $display("FAIL brake_reramp got=%0d want=%0d", high_b, SOFT ? 100 : 240); end
  endtask

  task automatic test_en_drop();
    int high_b;
    duty_set = 50;
    for (int p = 0; p < 8; p++) begin
      high_b = 0;
      if (p == 1) en = 1'b0;
      if (p == 5) en = 1'b1;
      for (int i = 0; i < CYC_PER; i++) begin
        if (p == 7 && i == 100) en = 1'b0;
        if (p == 7 && i == 120) en = 1'b1;
        step();
        high_b += int'(in_b);
        if (p == 7 && i == 110) begin
          total++;
          if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy_dn got=%b want=1", busy); end
        end
        total++;
        if ({in_a, in_b, busy, duty_cur} !== exp_vec()) begin
          bad++; $display("FAIL drop_cyc t=%0t got=%h want=%h", $time, {in_a, in_b, busy, duty_cur}, exp_vec());
        end
      end
      if (p == 1) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy_mid got=%b want=1", busy); end
      end
      if (p == 4) begin
        total += 2;
        if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle got=%b want=0", busy); end
        if (duty_cur !== '0) begin bad++; $display("FAIL drop_duty0 got=%0d want=0", duty_cur); end
      end
      if (p == 0 || p == 6 || p == 7) begin
        total++;
        if (duty_cur !== 12'd50) begin bad++; $display("FAIL drop_duty p=%0d got=%0d want=50", p, duty_cur); end
      end
    end
    total++;
    if (high_b != 200) begin bad++; $display("FAIL drop_nodead got=%0d want=200", high_b); end
`ifdef SOFT_START_EN
    // Release across a boundary, then re-request: resumes from the ramped-down duty.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < CYC_PER; i++) begin
        if (p == 0 && i == 390) en = 1'b0;
        if (p == 1 && i == 10) en = 1'b1;
        step();
        total++;
        if ({in_a, in_b, busy, duty_cur} !== exp_vec()) begin
          bad++; $display("FAIL resume_cyc t=%0t got=%h want=%h", $time, {in_a, in_b, busy, duty_cur}, exp_vec());
        end
      end
      total++;
      if (int'(duty_cur) != (p == 0 ? 25 : 50)) begin
        bad++; $display("FAIL resume_duty p=%0d got=%0d want=%0d", p, duty_cur, p == 0 ? 25 : 50);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    repeat (20) step();
    total++;
    if (in_b !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b want=1", in_b); end
    #2 rst = 1'b1;
    #1;
    total += 4;
    if (in_a !== 1'b0) begin bad++; $display("FAIL rstmid_in_a got=%b want=0", in_a); end
    if (in_b !== 1'b0) begin bad++; $display("FAIL rstmid_in_b got=%b want=0", in_b); end
    if (duty_cur !== '0) begin bad++; $display("FAIL rstmid_duty got=%0d want=0", duty_cur); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int len, pick;
    for (int seg = 0; seg < 30; seg++) begin
      len   = $urandom_range(600, 20);
      en    = ($urandom_range(9, 0) < 8);
      dir   = $urandom_range(1, 0);
      brake = ($urandom_range(99, 0) < 8);
      pick  = $urandom_range(3, 0);
      duty_set = (pick == 0) ? 12'd0 : (pick == 1) ? 12'hfff : CW'($urandom_range(120, 0));
      for (int i = 0; i < len; i++) begin
        step();
        total++;
        if ({in_a, in_b, busy, duty_cur} !== exp_vec()) begin
          bad++; $display("FAIL rand_cyc t=%0t got=%h want=%h", $time, {in_a, in_b, busy, duty_cur}, exp_vec());
        end
      end
    end
    brake = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_soft_start();
    test_clamp();
    test_reverse();
    test_brake();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
